// File: rtl/req_arbiter_8.sv
// Eight-way request arbiter with fixed-priority or round-robin selection and a bounded grant tenure.
// All outputs are registered; bit 7 wins under fixed priority.
module req_arbiter_8 #(
  parameter int MAX_HOLD    = 16,
  parameter int RR_PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [2:0] PTR_INIT  = 3'(RR_PTR_INIT);

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] last_id, last_id_nxt;
  logic       expired, expired_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] gnt_id_nxt;
  logic       gnt_vld_nxt;
  logic       busy_nxt;
  logic [7:0] cand;
  logic [3:0] arb;

  // Returns {found, winner}; round-robin searches upward from base with wrap.
  function automatic logic [3:0] arbitrate(input logic [7:0] c, input logic rr,
                                           input logic [2:0] base);
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    if (!rr) begin
      for (int i = 0; i < 8; i++) begin
        if (c[i]) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end else begin
      for (int k = 7; k >= 0; k--) begin
        idx = base + 3'(k);
        if (c[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
    return {found, win};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    ptr_nxt      = ptr;
    last_id_nxt  = last_id;
    expired_nxt  = expired;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    gnt_vld_nxt  = gnt_vld;
    busy_nxt     = busy;
    // The expired mask only ever applies to the one arbitration right after a timeout.
    cand = req & ~(expired ? (8'd1 << last_id) : 8'd0);
    arb  = arbitrate(cand, mode, ptr);

    case (state)
      IDLE, RELEASE: begin
        expired_nxt = 1'b0;
        if (arb[3]) begin
          state_nxt    = GRANT;
          gnt_nxt      = 8'd1 << arb[2:0];
          gnt_id_nxt   = arb[2:0];
          gnt_vld_nxt  = 1'b1;
          hold_cnt_nxt = 8'd0;
          busy_nxt     = 1'b1;
        end else begin
          state_nxt   = IDLE;
          gnt_nxt     = 8'd0;
          gnt_id_nxt  = 3'd0;
          gnt_vld_nxt = 1'b0;
          busy_nxt    = 1'b0;
        end
      end
      GRANT: begin
        hold_cnt_nxt = sat_inc(hold_cnt);
        if (!req[gnt_id] || (HOLD_EN && hold_cnt == HOLD_LAST)) begin
          // A dropped request takes precedence over a simultaneous timeout.
          expired_nxt = req[gnt_id];
          state_nxt   = RELEASE;
          gnt_nxt     = 8'd0;
          gnt_id_nxt  = 3'd0;
          gnt_vld_nxt = 1'b0;
          busy_nxt    = 1'b1;
          last_id_nxt = gnt_id;
          ptr_nxt     = gnt_id + 3'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        gnt_nxt     = 8'd0;
        gnt_id_nxt  = 3'd0;
        gnt_vld_nxt = 1'b0;
        busy_nxt    = 1'b0;
        expired_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      ptr      <= PTR_INIT;
      last_id  <= 3'd0;
      expired  <= 1'b0;
      gnt      <= 8'd0;
      gnt_id   <= 3'd0;
      gnt_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      ptr      <= ptr_nxt;
      last_id  <= last_id_nxt;
      expired  <= expired_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      gnt_vld  <= gnt_vld_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed bench for req_arbiter_8: five instances with different tenure limits share one stimulus.
// Expected grants are hand-derived per step.
module tb_req_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;

  logic [7:0] gnt_a  [0:4];
  logic [2:0] id_a   [0:4];
  logic       vld_a  [0:4];
  logic       busy_a [0:4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  req_arbiter_8 #(.MAX_HOLD(0), .RR_PTR_INIT(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_a[0]), .gnt_id(id_a[0]), .gnt_vld(vld_a[0]), .busy(busy_a[0]));
  req_arbiter_8 #(.MAX_HOLD(1), .RR_PTR_INIT(0)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_a[1]), .gnt_id(id_a[1]), .gnt_vld(vld_a[1]), .busy(busy_a[1]));
  req_arbiter_8 #(.MAX_HOLD(2), .RR_PTR_INIT(0)) u_h2 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_a[2]), .gnt_id(id_a[2]), .gnt_vld(vld_a[2]), .busy(busy_a[2]));
  req_arbiter_8 #(.MAX_HOLD(3), .RR_PTR_INIT(0)) u_h3 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_a[3]), .gnt_id(id_a[3]), .gnt_vld(vld_a[3]), .busy(busy_a[3]));
  req_arbiter_8 #(.MAX_HOLD(4), .RR_PTR_INIT(0)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gnt_a[4]), .gnt_id(id_a[4]), .gnt_vld(vld_a[4]), .busy(busy_a[4]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks gnt, gnt_id and gnt_vld of instance u against one expected one-hot grant.
  task automatic chk_g(input string tag, input int u, input logic [7:0] exp_gnt);
    logic [2:0] eid;
    eid = 3'd0;
    for (int i = 0; i < 8; i++) if (exp_gnt[i]) eid = 3'(i);
    chk({tag, "_gnt"}, gnt_a[u], exp_gnt);
    chk({tag, "_id"}, {5'd0, id_a[u]}, {5'd0, eid});
    chk({tag, "_vld"}, {7'd0, vld_a[u]}, {7'd0, |exp_gnt});
  endtask

  task automatic chk_busy(input string tag, input int u, input logic exp);
    chk(tag, {7'd0, busy_a[u]}, {7'd0, exp});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 8'h00;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with all requests high, then idle after release.
    rst  = 1'b1;
    req  = 8'hFF;
    mode = 1'b0;
    tick;
    tick;
    chk_g("rst", 0, 8'h00);
    chk_busy("rst_busy", 0, 1'b0);
    rst = 1'b0;
    req = 8'h00;
    tick;
    tick;
    chk_g("rst_idle", 0, 8'h00);
    chk_busy("rst_idle_busy", 0, 1'b0);

    // Fixed priority, unlimited tenure.
    mode = 1'b0;
    req  = 8'b0010_1010;
    tick;
    chk_g("fp_first", 0, 8'h20);
    chk_busy("fp_busy", 0, 1'b1);
    tick;
    chk_g("fp_hold", 0, 8'h20);
    req = 8'b0000_1010;
    tick;
    chk_g("fp_dead", 0, 8'h00);
    chk_busy("fp_dead_busy", 0, 1'b1);
    tick;
    chk_g("fp_next", 0, 8'h08);

    // Round-robin, two-cycle tenure, full request vector with wrap 7->0.
    do_reset;
    mode = 1'b1;
    req  = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk_g($sformatf("rr%0d_a", i), 2, 8'(1 << (i % 8)));
      tick;
      chk_g($sformatf("rr%0d_b", i), 2, 8'(1 << (i % 8)));
      tick;
      chk_g($sformatf("rr%0d_dead", i), 2, 8'h00);
    end

    // Hold expiry in fixed mode masks the timed-out requester once.
    do_reset;
    mode = 1'b0;
    req  = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_g($sformatf("exp_hi%0d", i), 4, 8'h80);
    end
    tick;
    chk_g("exp_dead", 4, 8'h00);
    tick;
    chk_g("exp_lo", 4, 8'h01);
    req = 8'h80;
    tick;
    chk_g("exp_drop", 4, 8'h00);
    tick;
    chk_g("exp_regrant", 4, 8'h80);

    // Lone requester expiry: two low cycles (RELEASE then IDLE).
    do_reset;
    mode = 1'b0;
    req  = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_g($sformatf("lone%0d", i), 3, 8'h04);
    end
    tick;
    chk_g("lone_rel", 3, 8'h00);
    chk_busy("lone_rel_busy", 3, 1'b1);
    tick;
    chk_g("lone_idle", 3, 8'h00);
    chk_busy("lone_idle_busy", 3, 1'b0);
    tick;
    chk_g("lone_again", 3, 8'h04);

    // One-cycle tenure.
    do_reset;
    mode = 1'b0;
    req  = 8'h02;
    tick;
    chk_g("mh1_g", 1, 8'h02);
    tick;
    chk_g("mh1_rel", 1, 8'h00);
    tick;
    chk_g("mh1_idle", 1, 8'h00);
    tick;
    chk_g("mh1_again", 1, 8'h02);

    // Mode change mid-grant, then asynchronous reset restores the pointer.
    do_reset;
    mode = 1'b1;
    req  = 8'h30;
    tick;
    chk_g("mc_rr", 0, 8'h10);
    mode = 1'b0;
    tick;
    chk_g("mc_hold", 0, 8'h10);
    req = 8'h20;
    tick;
    chk_g("mc_rel", 0, 8'h00);
    tick;
    chk_g("mc_g5", 0, 8'h20);
    req  = 8'h30;
    mode = 1'b1;
    tick;
    chk_g("mc_g5_hold", 0, 8'h20);
    #2;
    rst = 1'b1;
    #1;
    chk_g("async_rst", 0, 8'h00);
    chk_busy("async_rst_busy", 0, 1'b0);
    tick;
    rst = 1'b0;
    tick;
    chk_g("ptr_init", 0, 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
